// File: rtl/pong_pkg.sv
// Shared constants for the pong datapath: action encoding, field geometry and
// the paddle controller state encoding.
package pong_pkg;

    localparam logic [2:0] ACT_P0_UP = 3'd1;
    localparam logic [2:0] ACT_P0_DN = 3'd2;
    localparam logic [2:0] ACT_P1_UP = 3'd3;
    localparam logic [2:0] ACT_P1_DN = 3'd4;

    // HALF_PAD matches PAD_HEIGHT/2 in the AI stage.
    localparam logic signed [10:0] Y_MIN    = 11'sd0;
    localparam logic signed [10:0] Y_MAX    = 11'sd480;
    localparam logic signed [10:0] HALF_PAD = 11'sd40;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_MOVE
    } paddle_state_t;

    function automatic logic act_legal(input logic [2:0] act);
        return (act >= ACT_P0_UP) && (act <= ACT_P1_DN);
    endfunction

endpackage

// File: rtl/paddle_clamp.sv
// Combinational saturating move: y + step, computed wide so it cannot wrap,
// then limited to [lo, hi].
module paddle_clamp (
    input  logic signed [10:0] y,
    input  logic signed [10:0] step,
    input  logic signed [10:0] lo,
    input  logic signed [10:0] hi,
    output logic signed [10:0] y_next
);

    logic signed [11:0] sum;

    always_comb begin
        sum = 12'(y) + 12'(step);
        if (sum < 12'(lo)) begin
            y_next = lo;
        end else if (sum > 12'(hi)) begin
            y_next = hi;
        end else begin
            y_next = sum[10:0];
        end
    end

endmodule

// File: rtl/ai_paddle_ctrl.sv
// Per-frame paddle controller: waits for the AI action to settle, samples it,
// ramps the step on repeated actions and commits a clamped y update.
module ai_paddle_ctrl
    import pong_pkg::*;
#(
    parameter int               SETTLE_CYC = 4,
    parameter logic signed [10:0] BASE_STEP = 11'sd4,
    parameter logic signed [10:0] ACCEL     = 11'sd2,
    parameter logic signed [10:0] MAX_STEP  = 11'sd12,
    parameter logic signed [10:0] INIT_Y    = 11'sd240
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_tick,
    input  logic                enable,
    input  logic [2:0]          action,
    output logic signed [10:0]  paddle10_posy,
    output logic signed [10:0]  paddle11_posy,
    output logic                move_done,
    output logic                overrun,
    output logic                illegal_act
);

    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic signed [10:0] CLAMP_LO = Y_MIN + HALF_PAD;
    localparam logic signed [10:0] CLAMP_HI = Y_MAX - HALF_PAD;

    paddle_state_t      state;
    paddle_state_t      next_state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [2:0]         cur_act;
    logic [2:0]         last_act;
    logic signed [10:0] step;
    logic signed [10:0] step_next;
    logic signed [10:0] step_ramp;
    logic               do_sample;
    logic               do_commit;
    logic               set_overrun;

    logic               sel_p1;
    logic               dir_up;
    logic signed [10:0] y_sel;
    logic signed [10:0] delta;
    logic signed [10:0] y_new;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        cnt_next    = cnt;
        do_sample   = 1'b0;
        do_commit   = 1'b0;
        set_overrun = frame_tick && (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (frame_tick && enable) begin
                    next_state = ST_SETTLE;
                    cnt_next   = '0;
                end
            end
            ST_SETTLE: begin
                if (!enable) begin
                    next_state = ST_IDLE;
                end else if (cnt == CNT_LAST) begin
                    next_state = ST_SAMPLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (!enable) begin
                    next_state = ST_IDLE;
                end else begin
                    do_sample  = 1'b1;
                    next_state = ST_MOVE;
                end
            end
            ST_MOVE: begin
                do_commit  = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Step ramps only while the same legal action repeats frame after frame.
    always_comb begin
        step_ramp = step + ACCEL;
        if (step_ramp > MAX_STEP) begin
            step_ramp = MAX_STEP;
        end
        if (act_legal(action) && (action == last_act)) begin
            step_next = step_ramp;
        end else begin
            step_next = BASE_STEP;
        end
    end

    always_comb begin
        sel_p1 = (cur_act == ACT_P1_UP) || (cur_act == ACT_P1_DN);
        dir_up = (cur_act == ACT_P0_UP) || (cur_act == ACT_P1_UP);
        y_sel  = sel_p1 ? paddle11_posy : paddle10_posy;
        delta  = dir_up ? step : -step;
    end

    paddle_clamp u_clamp (
        .y      (y_sel),
        .step   (delta),
        .lo     (CLAMP_LO),
        .hi     (CLAMP_HI),
        .y_next (y_new)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt           <= '0;
            cur_act       <= 3'd0;
            last_act      <= 3'd0;
            step          <= BASE_STEP;
            paddle10_posy <= INIT_Y;
            paddle11_posy <= INIT_Y;
            move_done     <= 1'b0;
            overrun       <= 1'b0;
            illegal_act   <= 1'b0;
        end else begin
            cnt       <= cnt_next;
            move_done <= do_commit;
            if (set_overrun) begin
                overrun <= 1'b1;
            end
            if (do_sample) begin
                cur_act <= action;
                step    <= step_next;
                if (!act_legal(action)) begin
                    illegal_act <= 1'b1;
                end
            end
            if (do_commit) begin
                last_act <= cur_act;
                if (act_legal(cur_act)) begin
                    if (sel_p1) begin
                        paddle11_posy <= y_new;
                    end else begin
                        paddle10_posy <= y_new;
                    end
                end
            end
        end
    end

endmodule
